x_delay_line_ctrl: RTL and testbench

X_DELAY_LINE_CTRL -- requirements
Module: x_delay_line_ctrl

---
 rtl/x_delay_line_pkg.sv | 20 ++
 rtl/x_delay_line_ctrl_acc.sv | 75 +++++++
 rtl/x_delay_line_ctrl.sv | 134 +++++++++++++
 tb/tb_x_delay_line_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/x_delay_line_pkg.sv
// Shared types and defaults for the delay-line measurement controller.
package x_delay_line_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_HOLD,
    S_SHIFT,
    S_DONE
  } dl_state_e;

  localparam int DL_LENGTH_DEFAULT    = 128;
  localparam int CLEAR_CYCLES_DEFAULT = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/x_delay_line_ctrl_acc.sv
// Serial ones counter for the delay-line snapshot, with optional bubble detector
// (enabled by defining X_DL_CTRL_BUBBLE_CHECK_EN).
module x_delay_line_ctrl_acc
  import x_delay_line_pkg::*;
#(
  parameter int P_DL_LENGTH = DL_LENGTH_DEFAULT
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic                             en_i,
  input  logic                             bit_i,
  output logic [$clog2(P_DL_LENGTH+1)-1:0] count_o,
  output logic                             err_o
);

  localparam int CW = $clog2(P_DL_LENGTH + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(bit_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

`ifdef X_DL_CTRL_BUBBLE_CHECK_EN
  // Far-end cell arrives first, so a clean thermometer code reads 0...01...1.
  logic seen_one_q, seen_one_d;
  logic err_q, err_d;

  always_comb begin
    seen_one_d = seen_one_q;
    err_d      = err_q;
    if (clr_i) begin
      seen_one_d = 1'b0;
      err_d      = 1'b0;
    end else if (en_i) begin
      if (bit_i) begin
        seen_one_d = 1'b1;
      end else if (seen_one_q) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seen_one_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/x_delay_line_ctrl.sv
// Launch / capture / serial read-out sequencer for a tapped delay line.
// Optional bubble flag on o_err when X_DL_CTRL_BUBBLE_CHECK_EN is defined.
//
// state    | meaning
// IDLE     | waiting for i_start
// CLEAR    | flush line with 0 for P_CLEAR_CYCLES
// LAUNCH   | drive 1 into the line for one cycle
// HOLD     | capture disabled, snapshot frozen
// SHIFT    | serial read-out, P_DL_LENGTH samples
// DONE     | result committed; o_valid/o_count/o_err update on exit
module x_delay_line_ctrl
  import x_delay_line_pkg::*;
#(
  parameter int P_DL_LENGTH    = DL_LENGTH_DEFAULT,
  parameter int P_CLEAR_CYCLES = CLEAR_CYCLES_DEFAULT
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  output logic                             o_busy,
  output logic                             o_dl,
  output logic                             o_dl_en,
  output logic                             o_shift_en,
  input  logic                             i_shift,
  output logic [$clog2(P_DL_LENGTH+1)-1:0] o_count,
  output logic                             o_valid,
  output logic                             o_err
);

  localparam int CW = $clog2(P_DL_LENGTH + 1);
  localparam int TW = $clog2(max_int(P_CLEAR_CYCLES, P_DL_LENGTH));
  localparam logic [TW-1:0] CLEAR_LAST = TW'(P_CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] SHIFT_LAST = TW'(P_DL_LENGTH - 1);

  dl_state_e     state_q;
  logic [TW-1:0] tmr_q;
  logic          busy_q, dl_q, dl_en_q, shift_en_q, valid_q, err_q;
  logic [CW-1:0] count_q;

  logic          acc_clr;
  logic [CW-1:0] acc_count;
  logic          acc_err;

  assign acc_clr = (state_q == S_IDLE) && i_start;

  x_delay_line_ctrl_acc #(
    .P_DL_LENGTH(P_DL_LENGTH)
  ) u_acc (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .clr_i  (acc_clr),
    .en_i   (shift_en_q),
    .bit_i  (i_shift),
    .count_o(acc_count),
    .err_o  (acc_err)
  );

  // Outputs are loaded together with the state they belong to, so they are
  // registered yet aligned with state_q.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      busy_q     <= 1'b0;
      dl_q       <= 1'b0;
      dl_en_q    <= 1'b0;
      shift_en_q <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_CLEAR;
            tmr_q   <= CLEAR_LAST;
            busy_q  <= 1'b1;
            dl_en_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (tmr_q == '0) begin
            state_q <= S_LAUNCH;
            dl_q    <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_LAUNCH: begin
          state_q <= S_HOLD;
          dl_q    <= 1'b0;
          dl_en_q <= 1'b0;
        end
        S_HOLD: begin
          state_q    <= S_SHIFT;
          tmr_q      <= SHIFT_LAST;
          shift_en_q <= 1'b1;
        end
        S_SHIFT: begin
          if (tmr_q == '0) begin
            state_q    <= S_DONE;
            shift_en_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          count_q <= acc_count;
          err_q   <= acc_err;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          dl_q       <= 1'b0;
          dl_en_q    <= 1'b0;
          shift_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_dl       = dl_q;
  assign o_dl_en    = dl_en_q;
  assign o_shift_en = shift_en_q;
  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
// Self-checking bench for x_delay_line_ctrl: table vectors, random snapshots,
// back-to-back starts, ignored starts and mid-read-out reset.
module tb_x_delay_line_ctrl;

  localparam int C   = 2;
  localparam int N   = 128;
  localparam int CW  = $clog2(N + 1);
  localparam int LAT = C + N + 3;
`ifdef X_DL_CTRL_BUBBLE_CHECK_EN
  localparam bit BUB = 1'b1;
`else
  localparam bit BUB = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst, i_start, i_shift;
  logic          o_busy, o_dl, o_dl_en, o_shift_en, o_valid, o_err;
  logic [CW-1:0] o_count;

  always #5 i_clk = ~i_clk;

  x_delay_line_ctrl #(
    .P_DL_LENGTH   (N),
    .P_CLEAR_CYCLES(C)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_dl      (o_dl),
    .o_dl_en   (o_dl_en),
    .o_shift_en(o_shift_en),
    .i_shift   (i_shift),
    .o_count   (o_count),
    .o_valid   (o_valid),
    .o_err     (o_err)
  );

  typedef struct {
    int z0;
    int o1;
    int z1;
    int o2;
    int exp_count;
    bit exp_err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int last_count;
  bit last_err;
  bit pat[N];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    chk("inv_en_exclusive", 32'(o_dl_en & o_shift_en), 32'd0);
    chk("inv_dl_needs_en_busy", 32'(o_dl & ~(o_dl_en & o_busy)), 32'd0);
  endtask

  // Sample k is taken from pat[k]: pattern = z0 zeros, o1 ones, z1 zeros, o2 ones.
  task automatic fill(input vec_t v);
    for (int i = 0; i < N; i++) begin
      pat[i] = (i >= v.z0 && i < v.z0 + v.o1) ||
               (i >= v.z0 + v.o1 + v.z1 && i < v.z0 + v.o1 + v.z1 + v.o2);
    end
  endtask

  function automatic int ref_count();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(pat[i]);
    return s;
  endfunction

  // Non-thermometer iff some 1 is read before some later 0.
  function automatic bit ref_err();
    int first1 = N;
    int last0  = -1;
    for (int i = N - 1; i >= 0; i--) if (pat[i]) first1 = i;
    for (int i = 0; i < N; i++) if (!pat[i]) last0 = i;
    return BUB && (first1 < last0);
  endfunction

  function automatic logic [4:0] exp_ctl(input int t);
    logic b, d, de, se, v;
    b  = (t <= C + N + 2);
    d  = (t == C);
    de = (t <= C);
    se = (t >= C + 2) && (t < C + 2 + N);
    v  = (t == LAT);
    return {b, d, de, se, v};
  endfunction

  // Caller is at a negedge; i_start is raised here and sampled on the next edge.
  task automatic run(input string name, input int exp_count, input bit exp_err,
                     input bit start_noise);
    i_start = 1'b1;
    for (int t = 0; t <= LAT; t++) begin
      tick();
      i_start = start_noise && (t == 10 || t == 50);
      if (o_shift_en && t >= C + 2 && t < C + 2 + N) i_shift = pat[t - (C + 2)];
      else i_shift = 1'($urandom_range(0, 1));
      chk($sformatf("%s ctl t=%0d", name, t),
          32'({o_busy, o_dl, o_dl_en, o_shift_en, o_valid}), 32'(exp_ctl(t)));
      if (t == LAT || t == 0 || t == LAT - 1) begin
        chk($sformatf("%s count t=%0d", name, t), 32'(o_count),
            32'((t == LAT) ? exp_count : last_count));
        chk($sformatf("%s err t=%0d", name, t), 32'(o_err),
            32'((t == LAT) ? exp_err : last_err));
      end
    end
    last_count = exp_count;
    last_err   = exp_err;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_shift = 1'b0;
    repeat (3) tick();
    chk("reset_ctl", 32'({o_busy, o_dl, o_dl_en, o_shift_en, o_valid, o_err}), 32'd0);
    chk("reset_count", 32'(o_count), 32'd0);
    i_rst = 1'b0;
    tick();
    last_count = 0;
    last_err   = 1'b0;

    // Reset wins over a simultaneous start.
    i_rst   = 1'b1;
    i_start = 1'b1;
    tick();
    chk("rst_prio_busy", 32'(o_busy), 32'd0);
    i_rst   = 1'b0;
    i_start = 1'b0;
    tick();
    chk("rst_prio_stay_idle", 32'(o_busy), 32'd0);

    vecs[0] = '{100, 28, 0, 0, 28, 1'b0};
    vecs[1] = '{0, 128, 0, 0, 128, 1'b0};
    vecs[2] = '{128, 0, 0, 0, 0, 1'b0};
    vecs[3] = '{60, 10, 1, 57, 67, BUB};
    vecs[4] = '{0, 1, 127, 0, 1, BUB};
    vecs[5] = '{127, 1, 0, 0, 1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      fill(vecs[i]);
      run($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_err, 1'b0);
      repeat (3) tick();
      chk($sformatf("vec%0d hold_count", i), 32'(o_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d hold_valid", i), 32'(o_valid), 32'd0);
    end

    // Ignored starts mid-run, then a back-to-back start right after DONE.
    for (int i = 0; i < N; i++) pat[i] = 1'($urandom_range(0, 1));
    run("noise", ref_count(), ref_err(), 1'b1);
    for (int i = 0; i < N; i++) pat[i] = (i >= 90);
    run("b2b", ref_count(), ref_err(), 1'b0);
    tick();

    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) begin
        for (int i = 0; i < N; i++) pat[i] = 1'($urandom_range(0, 1));
      end else begin
        int m;
        m = int'($urandom_range(0, N));
        for (int i = 0; i < N; i++) pat[i] = (i >= N - m);
      end
      run($sformatf("rand%0d", r), ref_count(), ref_err(), 1'b0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    // Reset while sample 40 is on the bus: abandon run, clear the old result.
    fill(vecs[0]);
    run("pre_abort", 28, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < N; i++) pat[i] = 1'b1;
    i_start = 1'b1;
    for (int t = 0; t <= C + 2 + 40; t++) begin
      tick();
      i_start = 1'b0;
      if (o_shift_en && t >= C + 2) i_shift = pat[t - (C + 2)];
    end
    i_rst = 1'b1;
    tick();
    chk("abort_ctl", 32'({o_busy, o_dl, o_dl_en, o_shift_en, o_valid, o_err}), 32'd0);
    chk("abort_count", 32'(o_count), 32'd0);
    i_rst = 1'b0;
    for (int t = 0; t < LAT + 5; t++) begin
      tick();
      if (t % 16 == 0 || t == LAT) begin
        chk($sformatf("abort_quiet t=%0d", t), 32'({o_busy, o_valid}), 32'd0);
      end
    end
    last_count = 0;
    last_err   = 1'b0;

    fill(vecs[3]);
    run("recover", 67, BUB, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
